fetch_sequencer: RTL and testbench

//  Fetch-side controller that sequences the program counter and the instruction-memory request.
//  - Each fetched instruction is held for the decode stage until it is consumed.
//  - Branch and jump redirects are applied with priority.
//  - A fetch that is still outstanding when a redirect arrives is squashed.
//  - Sits between the PC register path and the instruction memory. Replaces the free-running PC+4.

---
 rtl/fetch_sequencer.sv | 140 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-side sequencer: drives the PC and the instruction-memory request,
// holds each fetched word for decode, and applies branch/jump redirects,
// squashing a fetch that is still in flight when a redirect arrives.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  S_IDLE | one cycle after reset, no request yet
//  S_REQ  | imem_req high at pc, waiting for imem_ack
//  S_HOLD | fetched word held on inst/inst_pc until decode consumes it
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WAIT_W   = 4,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_out,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    state_t            state, state_n;
    logic [31:0]       pc, pc_n;
    logic [31:0]       inst_n, inst_pc_n;
    logic              inst_valid_n;
    logic              fetch_err_n;
    logic              pend, pend_n;
    logic [31:0]       pend_tgt, pend_tgt_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic              redirect;
    logic [31:0]       redir_tgt;

    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;
    assign pc_out    = pc;

    // Next-state and next-register values; branch beats jump, targets word-aligned
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        inst_n       = inst;
        inst_pc_n    = inst_pc;
        inst_valid_n = inst_valid;
        fetch_err_n  = fetch_err;
        pend_n       = pend;
        pend_tgt_n   = pend_tgt;
        wait_n       = wait_cnt;
        redirect     = br_taken | jump;
        redir_tgt    = (br_taken ? br_target : jump_target) & ~32'd3;

        case (state)
            S_IDLE: begin
                state_n = S_REQ;
            end
            S_REQ: begin
                if (!imem_ack) begin
                    // pc is held so the address stays stable while requesting
                    wait_n = (wait_cnt == MAX_W) ? MAX_W : wait_cnt + WAIT_W'(1);
                    if (wait_n == MAX_W) begin
                        fetch_err_n = 1'b1;
                    end
                    if (redirect) begin
                        pend_n     = 1'b1;
                        pend_tgt_n = redir_tgt;
                    end
                end else if (pend || redirect) begin
                    // returned word belongs to the old path; drop it and refetch
                    pc_n   = redirect ? redir_tgt : pend_tgt;
                    pend_n = 1'b0;
                    wait_n = '0;
                end else begin
                    inst_n       = imem_rdata;
                    inst_pc_n    = pc;
                    inst_valid_n = 1'b1;
                    pc_n         = pc + 32'd4;
                    wait_n       = '0;
                    state_n      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    inst_valid_n = 1'b0;
                    pc_n         = redir_tgt;
                    state_n      = S_REQ;
                end else if (!stall) begin
                    inst_valid_n = 1'b0;
                    state_n      = S_REQ;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset also aborts any fetch in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
            pend       <= 1'b0;
            pend_tgt   <= '0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            inst       <= inst_n;
            inst_pc    <= inst_pc_n;
            inst_valid <= inst_valid_n;
            fetch_err  <= fetch_err_n;
            pend       <= pend_n;
            pend_tgt   <= pend_tgt_n;
            wait_cnt   <= wait_n;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_taken, jump, imem_ack;
    logic [31:0] br_target, jump_target, imem_rdata;
    logic        imem_req, inst_valid, fetch_err;
    logic [31:0] imem_addr, inst, inst_pc, pc_out;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .pc_out(pc_out), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    bit          m_started;   // first cycle after reset has elapsed
    bit          m_fetching;  // a request is outstanding
    bit          m_valid;
    bit          m_err;
    bit          m_pend;
    logic [31:0] m_pc, m_inst, m_ipc, m_ptgt;
    int          m_waits;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_started = 0; m_fetching = 0; m_valid = 0; m_err = 0; m_pend = 0;
        m_pc = 32'h0; m_inst = 0; m_ipc = 0; m_ptgt = 0; m_waits = 0;
    endfunction

    function automatic void model_step();
        bit          redir;
        logic [31:0] tgt;
        redir = br_taken | jump;
        tgt   = (br_taken ? br_target : jump_target);
        tgt   = {tgt[31:2], 2'b00};
        if (!m_started) begin
            m_started  = 1;
            m_fetching = 1;
        end else if (m_fetching) begin
            if (!imem_ack) begin
                if (m_waits < 15) m_waits++;
                if (m_waits == 15) m_err = 1;
                if (redir) begin m_pend = 1; m_ptgt = tgt; end
            end else if (m_pend || redir) begin
                m_pc    = redir ? tgt : m_ptgt;
                m_pend  = 0;
                m_waits = 0;
            end else begin
                m_inst = imem_rdata; m_ipc = m_pc; m_valid = 1;
                m_pc = m_pc + 32'd4; m_waits = 0; m_fetching = 0;
            end
        end else begin
            if (redir) begin
                m_valid = 0; m_pc = tgt; m_fetching = 1;
            end else if (!stall) begin
                m_valid = 0; m_fetching = 1;
            end
        end
    endfunction

    function automatic void compare_all();
        chk("imem_req",   {31'b0, imem_req},   {31'b0, m_fetching});
        chk("imem_addr",  imem_addr,           m_pc);
        chk("pc_out",     pc_out,              m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
        chk("inst",       inst,                m_inst);
        chk("inst_pc",    inst_pc,             m_ipc);
        chk("fetch_err",  {31'b0, fetch_err},  {31'b0, m_err});
    endfunction

    // drive one cycle of inputs from a negedge, advance the model, compare at next negedge
    task automatic step(input logic s, input logic b, input logic [31:0] bt,
                        input logic jj, input logic [31:0] jt,
                        input logic a, input logic [31:0] rd);
        stall = s; br_taken = b; br_target = bt; jump = jj; jump_target = jt;
        imem_ack = a; imem_rdata = rd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // asynchronous reset asserted between edges, released on a negedge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        stall = 0; br_taken = 0; jump = 0;
        model_reset();
        #1;
        chk("rst_req",   {31'b0, imem_req},   32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_pc",    pc_out,              32'd0);
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        imem_ack = 1'b0;
    endtask

    initial begin
        bit pb, pj;
        rst_n = 1'b0;
        stall = 0; br_taken = 0; br_target = 0; jump = 0; jump_target = 0;
        imem_ack = 0; imem_rdata = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // T1: IDLE then REQ at 0; reset asserted mid-wait
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t1_req", {31'b0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        chk("t1_idle", {31'b0, imem_req}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 32'hFFFF_0000);
        chk("t1_req2", {31'b0, imem_req}, 32'd1);
        chk("t1_valid", {31'b0, inst_valid}, 32'd0);

        // T2: sequential zero-wait fetches
        step(0, 0, 0, 0, 0, 1, 32'h11);
        chk("t2_inst0", inst, 32'h11);
        chk("t2_ipc0", inst_pc, 32'h0);
        chk("t2_req_low", {31'b0, imem_req}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h22);
        chk("t2_ipc1", inst_pc, 32'h4);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h33);
        chk("t2_inst2", inst, 32'h33);
        chk("t2_ipc2", inst_pc, 32'h8);

        // T3: stall in HOLD for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 1, 32'h99);
            chk("t3_inst", inst, 32'h33);
            chk("t3_req", {31'b0, imem_req}, 32'd0);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t3_addr", imem_addr, 32'hC);

        // T4: branch during wait, ack two cycles later is dropped
        step(0, 1, 32'h103, 0, 0, 0, 0);
        chk("t4_stable", imem_addr, 32'hC);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hDEAD);
        chk("t4_valid", {31'b0, inst_valid}, 32'd0);
        chk("t4_addr", imem_addr, 32'h100);

        // T5: branch + jump + ack together; then redirect in HOLD
        step(0, 1, 32'h200, 1, 32'h300, 1, 32'h5555);
        chk("t5_valid", {31'b0, inst_valid}, 32'd0);
        chk("t5_addr", imem_addr, 32'h200);
        step(0, 0, 0, 0, 0, 1, 32'h77);
        step(0, 0, 0, 1, 32'h402, 0, 0);
        chk("t5_squash", {31'b0, inst_valid}, 32'd0);
        chk("t5_addr2", imem_addr, 32'h400);

        // T6: timeout sets sticky error; jump to top of memory wraps
        for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("t6_err_pre", {31'b0, fetch_err}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t6_err", {31'b0, fetch_err}, 32'd1);
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h1);
        chk("t6_err_hold", {31'b0, fetch_err}, 32'd1);
        chk("t6_top", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 1, 32'hAA);
        chk("t6_ipc", inst_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t6_wrap", imem_addr, 32'h0);

        // random traffic with occasional async reset
        pb = 0; pj = 0;
        for (int c = 0; c < 3000; c++) begin
            logic s, b, jj, a;
            if (c % 700 == 350) begin
                do_reset();
                pb = 0; pj = 0;
            end
            s  = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 2) != 0);
            b  = !pb && ($urandom_range(0, 9) == 0);
            jj = !pj && ($urandom_range(0, 9) == 0);
            pb = b; pj = jj;
            step(s, b, $urandom, jj, $urandom, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
